// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register indices, exception codes, bit positions.
// Also holds the EPC victim-address helper used by the exception unit.
package cp0_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    localparam int SR_IE      = 0;
    localparam int SR_EXL     = 1;
    localparam int CAUSE_BD   = 31;
    localparam int IM_BASE    = 10;
    localparam int EXCCODE_LO = 2;

    // Delay-slot victims restart at the branch, and EPC is word aligned.
    function automatic logic [31:0] victim_pc(input logic [31:0] pc,
                                              input logic        bd);
        logic [31:0] p;
        p = bd ? (pc - 32'd4) : pc;
        return {p[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/cp0_exc_arb.sv
// Interrupt / exception arbitration for CP0.
// Interrupts win over synchronous exceptions; nothing fires while EXL=1.
module cp0_exc_arb
    import cp0_pkg::*;
#(
    parameter int NUM_HWINT = 6
) (
    input  logic [NUM_HWINT-1:0] ip_i,
    input  logic [NUM_HWINT-1:0] im_i,
    input  logic                 ie_i,
    input  logic                 exl_i,
    input  logic [4:0]           exccode_i,
    output logic                 req_o,
    output logic [4:0]           code_o
);

    logic int_req;
    logic exc_req;

    // Request terms and the ExcCode to record when a request is taken.
    always_comb begin
        int_req = ie_i & ~exl_i & (|(ip_i & im_i));
        exc_req = ~exl_i & (exccode_i != 5'd0);
        req_o   = int_req | exc_req;
        code_o  = int_req ? EXC_INT : exccode_i;
    end

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 exception and interrupt unit at the M stage.
// Holds SR/Cause/EPC/PRId and raises a one-cycle redirect request.
module cp0_exc_unit
    import cp0_pkg::*;
#(
    parameter int          NUM_HWINT = 6,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
    parameter logic [31:0] PRID      = 32'h2022_0707
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          m_pc,
    input  logic [4:0]           m_exccode,
    input  logic                 m_bd,
    input  logic [NUM_HWINT-1:0] hwint,
    input  logic                 we,
    input  logic [4:0]           a1,
    input  logic [4:0]           a2,
    input  logic [31:0]          wd,
    input  logic                 eret,
    output logic [31:0]          rd,
    output logic                 req,
    output logic [31:0]          exc_pc,
    output logic [31:0]          epc_out
);

    localparam logic NORMAL  = 1'b0;
    localparam logic HANDLER = 1'b1;

    logic [NUM_HWINT-1:0] im_q, im_d;
    logic [NUM_HWINT-1:0] ip_q, ip_d;
    logic                 ie_q, ie_d;
    logic                 exl_q, exl_d;
    logic                 bd_q, bd_d;
    logic [4:0]           code_q, code_d;
    logic [31:0]          epc_q, epc_d;

    logic [4:0]           arb_code;
    logic [31:0]          sr_w;
    logic [31:0]          cause_w;

    cp0_exc_arb #(
        .NUM_HWINT (NUM_HWINT)
    ) u_arb (
        .ip_i      (ip_q),
        .im_i      (im_q),
        .ie_i      (ie_q),
        .exl_i     (exl_q),
        .exccode_i (m_exccode),
        .req_o     (req),
        .code_o    (arb_code)
    );

    // Next state: a taken request kills the victim's mtc0/eret.
    always_comb begin
        ip_d   = hwint;
        im_d   = im_q;
        ie_d   = ie_q;
        exl_d  = exl_q;
        bd_d   = bd_q;
        code_d = code_q;
        epc_d  = epc_q;
        if (req) begin
            exl_d  = HANDLER;
            bd_d   = m_bd;
            code_d = arb_code;
            epc_d  = victim_pc(m_pc, m_bd);
        end else begin
            if (eret) begin
                exl_d = NORMAL;
            end
            if (we) begin
                case (a2)
                    CP0_SR: begin
                        im_d  = wd[IM_BASE +: NUM_HWINT];
                        exl_d = wd[SR_EXL];
                        ie_d  = wd[SR_IE];
                    end
                    CP0_EPC: epc_d = wd;
                    default: ;
                endcase
            end
        end
    end

    // CP0 register state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            im_q   <= '0;
            ip_q   <= '0;
            ie_q   <= 1'b0;
            exl_q  <= NORMAL;
            bd_q   <= 1'b0;
            code_q <= 5'd0;
            epc_q  <= 32'd0;
        end else begin
            im_q   <= im_d;
            ip_q   <= ip_d;
            ie_q   <= ie_d;
            exl_q  <= exl_d;
            bd_q   <= bd_d;
            code_q <= code_d;
            epc_q  <= epc_d;
        end
    end

    // Architectural views of SR and Cause, unused bits read as zero.
    always_comb begin
        sr_w                        = 32'd0;
        sr_w[IM_BASE +: NUM_HWINT]  = im_q;
        sr_w[SR_EXL]                = exl_q;
        sr_w[SR_IE]                 = ie_q;
        cause_w                     = 32'd0;
        cause_w[CAUSE_BD]           = bd_q;
        cause_w[IM_BASE +: NUM_HWINT] = ip_q;
        cause_w[EXCCODE_LO +: 5]    = code_q;
    end

    // mfc0 read mux, no write-through bypass.
    always_comb begin
        case (a1)
            CP0_SR:    rd = sr_w;
            CP0_CAUSE: rd = cause_w;
            CP0_EPC:   rd = epc_q;
            CP0_PRID:  rd = PRID;
            default:   rd = 32'd0;
        endcase
    end

    assign exc_pc  = EXC_ENTRY;
    assign epc_out = epc_q;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed self-checking bench for cp0_exc_unit.
// Covers default build and a NUM_HWINT=2 build sharing the stimulus bus.
module tb_cp0_exc_unit;

    localparam logic [31:0] ENTRY = 32'h0000_4180;
    localparam logic [31:0] PID   = 32'h2022_0707;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m_pc;
    logic [4:0]  m_exccode;
    logic        m_bd;
    logic [5:0]  hwint;
    logic [1:0]  hwint2;
    logic        we;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] wd;
    logic        eret;
    logic [31:0] rd, rd2;
    logic        req, req2;
    logic [31:0] exc_pc, exc_pc2;
    logic [31:0] epc_out, epc_out2;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    cp0_exc_unit dut (
        .clk       (clk),
        .reset     (reset),
        .m_pc      (m_pc),
        .m_exccode (m_exccode),
        .m_bd      (m_bd),
        .hwint     (hwint),
        .we        (we),
        .a1        (a1),
        .a2        (a2),
        .wd        (wd),
        .eret      (eret),
        .rd        (rd),
        .req       (req),
        .exc_pc    (exc_pc),
        .epc_out   (epc_out)
    );

    cp0_exc_unit #(.NUM_HWINT(2)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .m_pc      (m_pc),
        .m_exccode (m_exccode),
        .m_bd      (m_bd),
        .hwint     (hwint2),
        .we        (we),
        .a1        (a1),
        .a2        (a2),
        .wd        (wd),
        .eret      (eret),
        .rd        (rd2),
        .req       (req2),
        .exc_pc    (exc_pc2),
        .epc_out   (epc_out2)
    );

    task automatic idle();
        m_pc = 32'd0; m_exccode = 5'd0; m_bd = 1'b0;
        we = 1'b0; a2 = 5'd0; wd = 32'd0; eret = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rdreg(input logic [4:0] idx, output logic [31:0] v);
        a1 = idx;
        #1;
        v = rd;
    endtask

    task automatic mtc0(input logic [4:0] idx, input logic [31:0] v);
        we = 1'b1; a2 = idx; wd = v;
        tick();
        we = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        idle(); hwint = '0; hwint2 = '0; a1 = 5'd0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        rdreg(5'd12, v); tests++;
        if (v !== 32'd0) begin failed++; $display("FAIL reset_sr got %h exp %h", v, 32'd0); end
        rdreg(5'd13, v); tests++;
        if (v !== 32'd0) begin failed++; $display("FAIL reset_cause got %h exp %h", v, 32'd0); end
        rdreg(5'd14, v); tests++;
        if (v !== 32'd0) begin failed++; $display("FAIL reset_epc got %h exp %h", v, 32'd0); end
        rdreg(5'd15, v); tests++;
        if (v !== PID) begin failed++; $display("FAIL reset_prid got %h exp %h", v, PID); end
        tests++;
        if (req !== 1'b0) begin failed++; $display("FAIL reset_req got %b exp 0", req); end
        tests++;
        if (epc_out !== 32'd0) begin failed++; $display("FAIL reset_epc_out got %h exp 0", epc_out); end
        tests++;
        if (exc_pc !== ENTRY) begin failed++; $display("FAIL exc_pc got %h exp %h", exc_pc, ENTRY); end
    endtask

    task automatic test_interrupt();
        logic [31:0] v;
        mtc0(5'd12, 32'h0000_0401);
        hwint = 6'b000001;
        #1; tests++;
        if (req !== 1'b0) begin failed++; $display("FAIL int_latency got %b exp 0", req); end
        tick(); tests++;
        if (req !== 1'b1) begin failed++; $display("FAIL int_req got %b exp 1", req); end
        m_pc = 32'h0000_2007;
        tick(); m_pc = 32'd0;
        rdreg(5'd13, v); tests++;
        if (v !== 32'h0000_0400) begin failed++; $display("FAIL int_cause got %h exp %h", v, 32'h0000_0400); end
        rdreg(5'd12, v); tests++;
        if (v !== 32'h0000_0403) begin failed++; $display("FAIL int_sr got %h exp %h", v, 32'h0000_0403); end
        tests++;
        if (epc_out !== 32'h0000_2004) begin failed++; $display("FAIL int_epc got %h exp %h", epc_out, 32'h0000_2004); end
        tests++;
        if (req !== 1'b0) begin failed++; $display("FAIL int_exl_mask got %b exp 0", req); end
        hwint = '0;
        tick();
        mtc0(5'd12, 32'd0);
    endtask

    task automatic test_exc_bd();
        logic [31:0] v;
        m_exccode = 5'd12; m_bd = 1'b1; m_pc = 32'h0000_3010;
        #1; tests++;
        if (req !== 1'b1) begin failed++; $display("FAIL exc_req got %b exp 1", req); end
        tick(); idle();
        tests++;
        if (epc_out !== 32'h0000_300C) begin failed++; $display("FAIL exc_bd_epc got %h exp %h", epc_out, 32'h0000_300C); end
        rdreg(5'd13, v); tests++;
        if (v !== 32'h8000_0030) begin failed++; $display("FAIL exc_cause got %h exp %h", v, 32'h8000_0030); end
        rdreg(5'd12, v); tests++;
        if (v !== 32'h0000_0002) begin failed++; $display("FAIL exc_sr got %h exp %h", v, 32'h0000_0002); end
        mtc0(5'd12, 32'd0);
    endtask

    task automatic test_priority();
        logic [31:0] v;
        hwint = 6'b000001;
        mtc0(5'd12, 32'h0000_0401);
        m_exccode = 5'd4; m_pc = 32'h0000_5000;
        we = 1'b1; a2 = 5'd14; wd = 32'hDEAD_BEEF;
        #1; tests++;
        if (req !== 1'b1) begin failed++; $display("FAIL prio_req got %b exp 1", req); end
        tick(); idle();
        rdreg(5'd13, v); tests++;
        if (v !== 32'h0000_0400) begin failed++; $display("FAIL prio_cause got %h exp %h", v, 32'h0000_0400); end
        tests++;
        if (epc_out !== 32'h0000_5000) begin failed++; $display("FAIL prio_epc_drop got %h exp %h", epc_out, 32'h0000_5000); end
    endtask

    task automatic test_handler();
        logic [31:0] v;
        m_exccode = 5'd10; m_pc = 32'h0000_6000;
        #1; tests++;
        if (req !== 1'b0) begin failed++; $display("FAIL hdl_req got %b exp 0", req); end
        tick(); idle();
        rdreg(5'd13, v); tests++;
        if (v !== 32'h0000_0400) begin failed++; $display("FAIL hdl_cause got %h exp %h", v, 32'h0000_0400); end
        tests++;
        if (epc_out !== 32'h0000_5000) begin failed++; $display("FAIL hdl_epc got %h exp %h", epc_out, 32'h0000_5000); end
        eret = 1'b1;
        tick(); eret = 1'b0;
        rdreg(5'd12, v); tests++;
        if (v !== 32'h0000_0401) begin failed++; $display("FAIL eret_sr got %h exp %h", v, 32'h0000_0401); end
        tests++;
        if (req !== 1'b1) begin failed++; $display("FAIL eret_pending got %b exp 1", req); end
        m_pc = 32'h0000_7000;
        tick(); idle();
        hwint = '0;
        tests++;
        if (epc_out !== 32'h0000_7000) begin failed++; $display("FAIL reenter_epc got %h exp %h", epc_out, 32'h0000_7000); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] v;
        eret = 1'b1;
        mtc0(5'd12, 32'h0000_0403);
        eret = 1'b0;
        rdreg(5'd12, v); tests++;
        if (v !== 32'h0000_0403) begin failed++; $display("FAIL eret_mtc0_sr got %h exp %h", v, 32'h0000_0403); end
        mtc0(5'd12, 32'd0);
        m_exccode = 5'd8; eret = 1'b1; m_pc = 32'h0000_8000;
        #1; tests++;
        if (req !== 1'b1) begin failed++; $display("FAIL req_eret_req got %b exp 1", req); end
        tick(); idle();
        rdreg(5'd12, v); tests++;
        if (v !== 32'h0000_0002) begin failed++; $display("FAIL req_eret_sr got %h exp %h", v, 32'h0000_0002); end
        mtc0(5'd13, 32'hFFFF_FFFF);
        rdreg(5'd13, v); tests++;
        if (v !== 32'h0000_0020) begin failed++; $display("FAIL cause_ro got %h exp %h", v, 32'h0000_0020); end
        mtc0(5'd15, 32'h1111_1111);
        rdreg(5'd15, v); tests++;
        if (v !== PID) begin failed++; $display("FAIL prid_ro got %h exp %h", v, PID); end
        mtc0(5'd12, 32'd0);
    endtask

    task automatic test_epc_write();
        logic [31:0] v;
        we = 1'b1; a2 = 5'd14; wd = 32'h1234_5677;
        #1; tests++;
        if (epc_out !== 32'h0000_8000) begin failed++; $display("FAIL epc_no_bypass got %h exp %h", epc_out, 32'h0000_8000); end
        tick(); idle();
        tests++;
        if (epc_out !== 32'h1234_5677) begin failed++; $display("FAIL epc_write got %h exp %h", epc_out, 32'h1234_5677); end
        rdreg(5'd0, v); tests++;
        if (v !== 32'd0) begin failed++; $display("FAIL rd_idx0 got %h exp 0", v); end
        rdreg(5'd16, v); tests++;
        if (v !== 32'd0) begin failed++; $display("FAIL rd_idx16 got %h exp 0", v); end
    endtask

    task automatic test_reset_mid_handler();
        logic [31:0] v;
        m_exccode = 5'd5; m_pc = 32'h0000_9000;
        tick(); idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rdreg(5'd12, v); tests++;
        if (v !== 32'd0) begin failed++; $display("FAIL rst_mid_sr got %h exp 0", v); end
        m_exccode = 5'd10;
        #1; tests++;
        if (req !== 1'b1) begin failed++; $display("FAIL rst_mid_normal got %b exp 1", req); end
        idle();
    endtask

    task automatic test_hwint2();
        logic [31:0] v;
        reset = 1'b1; tick(); reset = 1'b0;
        hwint2 = 2'b01;
        mtc0(5'd12, 32'h0000_0801);
        tick(); tests++;
        if (req2 !== 1'b0) begin failed++; $display("FAIL hw2_masked got %b exp 0", req2); end
        hwint2 = 2'b10;
        tick(); tests++;
        if (req2 !== 1'b1) begin failed++; $display("FAIL hw2_req got %b exp 1", req2); end
        tick();
        hwint2 = 2'b00;
        mtc0(5'd12, 32'hFFFF_FFFF);
        a1 = 5'd12; #1; v = rd2; tests++;
        if (v !== 32'h0000_0C03) begin failed++; $display("FAIL hw2_sr got %h exp %h", v, 32'h0000_0C03); end
    endtask

    initial begin
        test_reset();
        test_interrupt();
        test_exc_bd();
        test_priority();
        test_handler();
        test_simultaneous();
        test_epc_write();
        test_reset_mid_handler();
        test_hwint2();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
